frame_loader: RTL and testbench
===============================

FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 60000, bytes per frame (800x600 1bpp).
REQ-002 SHALL have parameter ADDR_W, default 16, bank address width; FRAME_BYTES <= 2**ADDR_W.
REQ-003 SHALL have port CLK_40  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_data_FSM  input  1  one-cycle pulse from mode FSM; begin streaming.
REQ-006 SHALL have port switch_mode  input  1  one-cycle pulse; read/write banks swap.
REQ-007 SHALL have port rx_data  input  8  frame byte from stream source.
REQ-008 SHALL have port rx_valid  input  1  rx_data valid.
REQ-009 SHALL have port rx_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port wr_en_b1  output  1  write strobe, bank 1.
REQ-011 SHALL have port wr_en_b2  output  1  write strobe, bank 2.
REQ-012 SHALL have port wr_addr  output  ADDR_W  byte address for active write strobe.
REQ-013 SHALL have port wr_data  output  8  byte for active write strobe.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse, full frame written.
REQ-015 SHALL have port underrun  output  1  one-cycle pulse, swap arrived before frame complete.
REQ-016 SHALL have port underrun_count  output  8  saturating underrun tally (see Configuration).

Function
REQ-017 SHALL implement states IDLE, LOAD, DONE.
REQ-018 IDLE: rx_ready=0; on start_data_FSM -> LOAD, write bank = bank 2, byte address = 0.
REQ-019 LOAD: rx_ready=1 (combinational from state); a byte is accepted when rx_valid & rx_ready.
REQ-020 Each accepted byte SHALL produce, one cycle later, exactly one of wr_en_b1/wr_en_b2 high with wr_addr = its index and wr_data = the byte; write strobes never both high.
REQ-021 Byte address SHALL increment by 1 per accepted byte; accepting index FRAME_BYTES-1 -> DONE, frame_done pulses in the same cycle as that byte's write strobe.
REQ-022 DONE: rx_ready=0; no writes; wait for switch_mode.
REQ-023 switch_mode in LOAD or DONE SHALL toggle the write bank, reset address to 0, enter LOAD next cycle.
REQ-024 switch_mode in LOAD with address < FRAME_BYTES SHALL pulse underrun one cycle later; remaining bytes of the abandoned frame are not written.
REQ-025 switch_mode in the same cycle the last byte is accepted: byte written, frame_done pulses, no underrun, toggle and restart apply.
REQ-026 switch_mode in IDLE SHALL be ignored.
REQ-027 start_data_FSM outside IDLE SHALL resynchronise: write bank = bank 2, address 0, LOAD; no underrun; takes priority over simultaneous switch_mode.
REQ-028 A byte accepted in the same cycle as a switch_mode or start_data_FSM SHALL still be written to the old bank/address.

Reset
REQ-029 On reset: state IDLE, write bank = bank 2, address 0, rx_ready/wr_en_b1/wr_en_b2/frame_done/underrun = 0, wr_addr = 0, wr_data = 0, underrun_count = 0.
REQ-030 Reset mid-LOAD SHALL abort immediately; a pending write strobe SHALL not appear after reset.

Configuration
REQ-031 With FRAME_LOADER_STATS_EN defined, underrun_count SHALL increment on each underrun pulse, saturating at 255, cleared only by reset.
REQ-032 Without FRAME_LOADER_STATS_EN, underrun_count SHALL be constant 0 and no counter logic SHALL exist; all other behaviour unchanged.

Verification (FRAME_BYTES=4)
REQ-033 Reset, start_data_FSM, rx_valid=1 bytes 0xA0..0xA3 -> wr_en_b2 at addr 0..3 with A0..A3, frame_done with addr 3 write, rx_ready=0 after.
REQ-034 From DONE, switch_mode then bytes 0xB0..0xB3 -> wr_en_b1 addr 0..3; second switch_mode -> writes return to bank 2.
REQ-035 switch_mode after 2 of 4 bytes -> underrun one pulse, next byte written to other bank addr 0; underrun_count=1 (macro on) / 0 (macro off).
REQ-036 switch_mode coincident with 4th byte -> 4th byte written old bank addr 3, frame_done=1, underrun=0, next byte new bank addr 0.
REQ-037 rx_valid toggling 1/0 during LOAD -> writes only on valid cycles, addresses contiguous; switch_mode in IDLE -> no writes, rx_ready=0.
REQ-038 Assert reset after 2 bytes -> all outputs 0 next cycle, no strobe; start_data_FSM then restarts bank 2 addr 0.

Source files
------------

// File: rtl/frame_loader.sv
// Frame loader: streams rx bytes into one of two frame banks, swapping banks on switch_mode.
// Optional underrun statistics counter is enabled with `define FRAME_LOADER_STATS_EN.
module frame_loader #(
    parameter int FRAME_BYTES = 60000,
    parameter int ADDR_W      = 16
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              start_data_FSM,
    input  logic              switch_mode,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en_b1,
    output logic              wr_en_b2,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              underrun,
    output logic [7:0]        underrun_count,
    output logic [1:0]        state_dbg
);

    // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
    // rx_ready depends only on the current state, never on rx_valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

    state_t              state_q, state_d;
    logic                bank_b1_q, bank_b1_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_b1_q, wr_en_b1_d;
    logic                wr_en_b2_q, wr_en_b2_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;
    logic                accept;
    logic                last_byte;

    assign rx_ready   = (state_q == S_LOAD);
    assign accept     = rx_valid && rx_ready;
    assign last_byte  = accept && (addr_q == LAST_ADDR);

    always_comb begin
        state_d      = state_q;
        bank_b1_d    = bank_b1_q;
        addr_d       = addr_q;
        wr_en_b1_d   = 1'b0;
        wr_en_b2_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;

        // The accepted byte always lands in the bank/address current this cycle,
        // even if a swap or resync is also requested.
        if (accept) begin
            wr_en_b1_d = bank_b1_q;
            wr_en_b2_d = !bank_b1_q;
            wr_addr_d  = addr_q;
            wr_data_d  = rx_data;
            if (last_byte) begin
                frame_done_d = 1'b1;
                state_d      = S_DONE;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        if (start_data_FSM) begin
            state_d   = S_LOAD;
            bank_b1_d = 1'b0;
            addr_d    = '0;
        end else if (switch_mode && state_q != S_IDLE) begin
            state_d    = S_LOAD;
            bank_b1_d  = !bank_b1_q;
            addr_d     = '0;
            underrun_d = (state_q == S_LOAD) && !last_byte;
        end
    end

`ifdef FRAME_LOADER_STATS_EN
    logic [7:0] underrun_count_q, underrun_count_d;

    always_comb begin
        underrun_count_d = underrun_count_q;
        if (underrun_d && underrun_count_q != 8'hFF) begin
            underrun_count_d = underrun_count_q + 8'd1;
        end
    end

    assign underrun_count = underrun_count_q;
`else
    assign underrun_count = 8'd0;
`endif

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bank_b1_q    <= 1'b0;
            addr_q       <= '0;
            wr_en_b1_q   <= 1'b0;
            wr_en_b2_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'd0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef FRAME_LOADER_STATS_EN
            underrun_count_q <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            bank_b1_q    <= bank_b1_d;
            addr_q       <= addr_d;
            wr_en_b1_q   <= wr_en_b1_d;
            wr_en_b2_q   <= wr_en_b2_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
`ifdef FRAME_LOADER_STATS_EN
            underrun_count_q <= underrun_count_d;
`endif
        end
    end

    assign wr_en_b1   = wr_en_b1_q;
    assign wr_en_b2   = wr_en_b2_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader with FRAME_BYTES=4: directed vector table, reset corner
// sequences, then randomized traffic against a bank/index reference model.
`timescale 1ns/1ps
module tb_frame_loader;
    localparam int FB = 4;
    localparam int AW = 16;

    logic          CLK_40;
    logic          reset;
    logic          start_data_FSM;
    logic          switch_mode;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en_b1;
    logic          wr_en_b2;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done;
    logic          underrun;
    logic [7:0]    underrun_count;
    logic [1:0]    state_dbg;

    frame_loader #(.FRAME_BYTES(FB), .ADDR_W(AW)) dut (
        .CLK_40(CLK_40), .reset(reset), .start_data_FSM(start_data_FSM),
        .switch_mode(switch_mode), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en_b1(wr_en_b1), .wr_en_b2(wr_en_b2),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
        .underrun(underrun), .underrun_count(underrun_count), .state_dbg(state_dbg)
    );

    // clock / reset
    initial CLK_40 = 1'b0;
    always #10 CLK_40 = ~CLK_40;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic          s;
        logic          sw;
        logic          v;
        logic [7:0]    d;
        logic          rdy;
        logic          b1;
        logic          b2;
        logic [AW-1:0] a;
        logic [7:0]    wd;
        logic          fd;
        logic          ur;
    } vec_t;

    vec_t tbl[$];

    // reference model: which bank is filling, next byte index, whether loading
    bit m_started;
    bit m_loading;
    int m_bank;
    int m_idx;
    int m_cnt;

    function automatic int exp_count();
`ifdef FRAME_LOADER_STATS_EN
        return (m_cnt > 255) ? 255 : m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_loading = 0;
        m_bank    = 2;
        m_idx     = 0;
        m_cnt     = 0;
    endtask

    task automatic model_step(input logic s, input logic sw, input logic v, input logic [7:0] d,
                              output vec_t e);
        bit was_loading;
        bit last;
        e = '0;
        e.s = s; e.sw = sw; e.v = v; e.d = d;
        e.rdy = m_loading;
        was_loading = m_loading;
        last = 0;
        if (v && m_loading) begin
            if (m_bank == 1) e.b1 = 1'b1; else e.b2 = 1'b1;
            e.a  = AW'(m_idx);
            e.wd = d;
            last = (m_idx == FB - 1);
            e.fd = last;
            m_idx++;
            if (last) m_loading = 0;
        end
        if (s) begin
            m_bank = 2; m_idx = 0; m_loading = 1; m_started = 1;
        end else if (sw && m_started) begin
            e.ur = was_loading && !last;
            if (e.ur) m_cnt++;
            m_bank = 3 - m_bank; m_idx = 0; m_loading = 1;
        end
    endtask

    // driver: apply one cycle of inputs, check rx_ready before the edge, outputs after it
    task automatic apply(input vec_t e, input string tag);
        @(negedge CLK_40);
        start_data_FSM = e.s;
        switch_mode    = e.sw;
        rx_valid       = e.v;
        rx_data        = e.d;
        #1;
        chk({tag, "_ready"}, 64'(rx_ready), 64'(e.rdy));
        @(posedge CLK_40);
        #1;
        chk({tag, "_flags"}, 64'({wr_en_b1, wr_en_b2, frame_done, underrun}),
            64'({e.b1, e.b2, e.fd, e.ur}));
        if (e.b1 || e.b2) begin
            chk({tag, "_addr"}, 64'(wr_addr), 64'(e.a));
            chk({tag, "_data"}, 64'(wr_data), 64'(e.wd));
        end
    endtask

    task automatic add(input logic s, input logic sw, input logic v, input logic [7:0] d,
                       input logic rdy, input logic b1, input logic b2, input logic [AW-1:0] a,
                       input logic [7:0] wd, input logic fd, input logic ur);
        vec_t e;
        e = '{s: s, sw: sw, v: v, d: d, rdy: rdy, b1: b1, b2: b2, a: a, wd: wd, fd: fd, ur: ur};
        tbl.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {27'd0, rx_ready, wr_en_b1, wr_en_b2, frame_done, underrun, wr_addr, wr_data, underrun_count},
            64'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK_40);
        reset = 1'b1;
        start_data_FSM = 1'b0; switch_mode = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        #1;
        check_all_zero("reset_async");
        @(posedge CLK_40);
        #1;
        check_all_zero("reset_held");
        @(negedge CLK_40);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        vec_t e;
        reset = 1'b1;
        start_data_FSM = 1'b0; switch_mode = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        model_reset();

        //   s  sw v  data   rdy b1 b2 addr   wdata  fd ur
        add(1, 0, 0, 8'h00, 0, 0, 0, 16'd0, 8'h00, 0, 0);
        add(0, 0, 1, 8'hA0, 1, 0, 1, 16'd0, 8'hA0, 0, 0);
        add(0, 0, 1, 8'hA1, 1, 0, 1, 16'd1, 8'hA1, 0, 0);
        add(0, 0, 1, 8'hA2, 1, 0, 1, 16'd2, 8'hA2, 0, 0);
        add(0, 0, 1, 8'hA3, 1, 0, 1, 16'd3, 8'hA3, 1, 0);
        add(0, 0, 1, 8'hFF, 0, 0, 0, 16'd0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 0, 16'd0, 8'h00, 0, 0);
        add(0, 0, 1, 8'hB0, 1, 1, 0, 16'd0, 8'hB0, 0, 0);
        add(0, 0, 1, 8'hB1, 1, 1, 0, 16'd1, 8'hB1, 0, 0);
        add(0, 0, 1, 8'hB2, 1, 1, 0, 16'd2, 8'hB2, 0, 0);
        add(0, 0, 1, 8'hB3, 1, 1, 0, 16'd3, 8'hB3, 1, 0);
        add(0, 1, 0, 8'h00, 0, 0, 0, 16'd0, 8'h00, 0, 0);
        add(0, 0, 1, 8'hC0, 1, 0, 1, 16'd0, 8'hC0, 0, 0);
        add(0, 0, 1, 8'hC1, 1, 0, 1, 16'd1, 8'hC1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 0, 16'd0, 8'h00, 0, 1);
        add(0, 0, 1, 8'hD0, 1, 1, 0, 16'd0, 8'hD0, 0, 0);
        add(0, 0, 1, 8'hD1, 1, 1, 0, 16'd1, 8'hD1, 0, 0);
        add(0, 0, 1, 8'hD2, 1, 1, 0, 16'd2, 8'hD2, 0, 0);
        add(0, 1, 1, 8'hD3, 1, 1, 0, 16'd3, 8'hD3, 1, 0);
        add(0, 0, 1, 8'hE0, 1, 0, 1, 16'd0, 8'hE0, 0, 0);
        add(0, 0, 0, 8'h77, 1, 0, 0, 16'd0, 8'h00, 0, 0);
        add(0, 0, 1, 8'hE1, 1, 0, 1, 16'd1, 8'hE1, 0, 0);
        add(0, 0, 0, 8'h78, 1, 0, 0, 16'd0, 8'h00, 0, 0);
        add(0, 0, 1, 8'hE2, 1, 0, 1, 16'd2, 8'hE2, 0, 0);
        add(1, 1, 1, 8'hE3, 1, 0, 1, 16'd3, 8'hE3, 1, 0);
        add(0, 0, 1, 8'hF0, 1, 0, 1, 16'd0, 8'hF0, 0, 0);

        do_reset();
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
`ifdef FRAME_LOADER_STATS_EN
        chk("table_ucount", 64'(underrun_count), 64'd1);
`else
        chk("table_ucount", 64'(underrun_count), 64'd0);
`endif

        // reset mid-load: byte in flight must not surface after reset
        do_reset();
        apply('{s: 1, default: 0}, "mid_start");
        apply('{v: 1, d: 8'h11, rdy: 1, b2: 1, a: 16'd0, wd: 8'h11, default: 0}, "mid_b0");
        @(negedge CLK_40);
        rx_valid = 1'b1; rx_data = 8'h22;
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset_async");
        @(posedge CLK_40);
        #1;
        check_all_zero("mid_reset_edge");
        @(negedge CLK_40);
        reset = 1'b0;
        model_reset();
        apply('{sw: 1, v: 1, d: 8'h33, default: 0}, "idle_switch");
        apply('{v: 1, d: 8'h34, default: 0}, "idle_valid");
        apply('{s: 1, default: 0}, "restart");
        apply('{v: 1, d: 8'h44, rdy: 1, b2: 1, a: 16'd0, wd: 8'h44, default: 0}, "restart_b0");

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic s, sw, v;
            logic [7:0] d;
            s  = ($urandom_range(0, 99) < 3);
            sw = ($urandom_range(0, 99) < 8);
            v  = ($urandom_range(0, 99) < 70);
            d  = 8'($urandom_range(0, 255));
            model_step(s, sw, v, d, e);
            apply(e, "rand");
            chk("rand_ucount", 64'(underrun_count), 64'(exp_count()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // mutually exclusive write strobes, checked every cycle
    always @(negedge CLK_40) begin
        if (!reset && wr_en_b1 && wr_en_b2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobes_exclusive: got both high expected at most one at %0t", $time);
        end
    end

endmodule
